pipe_stage_skid: RTL and testbench

Parametrised, elastic pipeline-stage register that generalises the fixed stall/flush stage registers between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload plus an exception code. A valid/ready handshake replaces the global stall. An optional skid buffer gives full throughput with a registered `in_ready`. An exception fence keeps exceptions precise, and a saturating counter measures back-pressure. One instance sits between each pair of pipeline stages.

---
 rtl/pipe_stage_skid.sv | 132 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with exception fence and stall counter.
// Define PIPE_STAGE_SKID_EN to add the skid register (registered in_ready).
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q;
  logic [DATA_W-1:0]  m_data_q;
  logic [EXC_W-1:0]   m_exc_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  logic m_valid;
  logic fence;
  logic in_hs;
  logic out_hs;
  logic stall;

  assign m_valid = (state_q != EMPTY);

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0]  s_data_q;
  logic [EXC_W-1:0]   s_exc_q;
  logic               s_valid;

  assign s_valid  = (state_q == FULL);
  // Invalid entries hold zero exc, so no valid qualifier is needed.
  assign fence    = (|m_exc_q) || (|s_exc_q);
  assign in_ready = !reset && !s_valid && !fence && !flush;
`else
  assign fence    = |m_exc_q;
  assign in_ready = !reset && (!m_valid || out_ready)
                    && !fence && !flush;
`endif

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = m_valid && out_ready;
  assign stall     = m_valid && !out_ready;

  assign out_valid = m_valid;
  assign out_data  = m_data_q;
  assign out_exc   = m_exc_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q  <= EMPTY;
      m_data_q <= '0;
      m_exc_q  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      s_data_q <= '0;
      s_exc_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_hs) begin
            state_q  <= ONE;
            m_data_q <= in_data;
            m_exc_q  <= in_exc;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            m_data_q <= in_data;
            m_exc_q  <= in_exc;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_hs) begin
            state_q  <= FULL;
            s_data_q <= in_data;
            s_exc_q  <= in_exc;
`endif
          end else if (out_hs) begin
            state_q  <= EMPTY;
            m_data_q <= '0;
            m_exc_q  <= '0;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          if (out_hs) begin
            state_q  <= ONE;
            m_data_q <= s_data_q;
            m_exc_q  <= s_exc_q;
            s_data_q <= '0;
            s_exc_q  <= '0;
          end
        end
`endif
        default: begin
          state_q  <= EMPTY;
          m_data_q <= '0;
          m_exc_q  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid; covers both skid build options.
// Expected beats are queued on input handshake, compared on output.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int EW = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [EW-1:0] in_exc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_exc;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [EW-1:0] e;
  } beat_t;

  beat_t sb[$];
  int    passed = 0;
  int    total  = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(DW),
    .EXC_W (EW),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_exc   (in_exc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_exc  (out_exc),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs; queue the beat if the stage takes it.
  task automatic drive(input logic iv, input logic [DW-1:0] d,
                       input logic [EW-1:0] e, input logic ordy,
                       input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_exc    = e;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (in_valid && in_ready) sb.push_back({d, e});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    beat_t got;
    reset = 1'b1;
    drive(1'b1, 32'hDEAD, '0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hDEAD, '0, 1'b1, 1'b0);
    got = {out_data, out_exc};
    total++;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid);
    else passed++;
    total++;
    if (got !== '0) $display("FAIL rst_out_data got %h exp 0", got);
    else passed++;
    total++;
    if (occupancy !== 2'd0) $display("FAIL rst_occ got %0d exp 0", occupancy);
    else passed++;
    total++;
    if (stall_cnt !== '0) $display("FAIL rst_stall got %0d exp 0", stall_cnt);
    else passed++;
    tick();
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    total++;
    if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", in_ready);
    else passed++;
    tick();
    sb.delete();
  endtask

  task automatic test_stream();
    beat_t exp;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(c < 8, DW'(c + 1), '0, 1'b1, 1'b0);
      if (c >= 1 && c <= 8) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== DW'(c))
          $display("FAIL stream_lat c=%0d got v=%b d=%h exp d=%h",
                   c, out_valid, out_data, c);
        else passed++;
      end
      if (c == 4) begin
        total++;
        if (occupancy !== 2'd1) $display("FAIL stream_occ got %0d exp 1", occupancy);
        else passed++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL stream_sb got %h exp none", out_data);
        else begin
          exp = sb.pop_front();
          if ({out_data, out_exc} !== exp)
            $display("FAIL stream_sb got %h/%0d exp %h/%0d",
                     out_data, out_exc, exp.d, exp.e);
          else passed++;
        end
      end
      tick();
    end
    total++;
    if (stall_cnt !== '0) $display("FAIL stream_stall got %0d exp 0", stall_cnt);
    else passed++;
    total++;
    if (sb.size() != 0) $display("FAIL stream_left got %0d exp 0", sb.size());
    else passed++;
  endtask

  task automatic test_fence();
    beat_t exp;
    do_reset();
    drive(1'b1, 32'h77, 2'd2, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b1) $display("FAIL fence_accept got %b exp 1", in_ready);
    else passed++;
    tick();
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) drive(1'b0, '0, '0, 1'b1, 1'b0);
      else drive(1'b1, 32'h55, '0, (c >= 3), 1'b0);
      if (c <= 3) begin
        total++;
        if (in_ready !== 1'b0) $display("FAIL fence_hold c=%0d got %b exp 0", c, in_ready);
        else passed++;
      end
      if (c == 4) begin
        total++;
        if (in_ready !== 1'b1) $display("FAIL fence_release got %b exp 1", in_ready);
        else passed++;
      end
      if (c == 5) begin
        total++;
        if (out_valid !== 1'b1) $display("FAIL fence_next got %b exp 1", out_valid);
        else passed++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL fence_sb got %h exp none", out_data);
        else begin
          exp = sb.pop_front();
          if ({out_data, out_exc} !== exp)
            $display("FAIL fence_sb got %h/%0d exp %h/%0d",
                     out_data, out_exc, exp.d, exp.e);
          else passed++;
        end
      end
      tick();
    end
    total++;
    if (sb.size() != 0) $display("FAIL fence_left got %0d exp 0", sb.size());
    else passed++;
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_skid();
    beat_t exp;
    do_reset();
    drive(1'b1, 32'hA, '0, 1'b0, 1'b0);
    tick();
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) drive(1'b0, '0, '0, 1'b1, 1'b0);
      else if (c == 1) drive(1'b1, 32'hB, '0, 1'b0, 1'b0);
      else drive(1'b1, 32'hC, '0, (c >= 4), 1'b0);
      if (c == 1) begin
        total++;
        if (in_ready !== 1'b1 || occupancy !== 2'd1)
          $display("FAIL skid_absorb got rdy=%b occ=%0d exp 1/1", in_ready, occupancy);
        else passed++;
      end
      if (c >= 2 && c <= 4) begin
        total++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_data !== 32'hA)
          $display("FAIL skid_full c=%0d got rdy=%b occ=%0d d=%h exp 0/2/a",
                   c, in_ready, occupancy, out_data);
        else passed++;
      end
      if (c == 6) begin
        total++;
        if (stall_cnt !== 4'd3) $display("FAIL skid_stall got %0d exp 3", stall_cnt);
        else passed++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL skid_sb got %h exp none", out_data);
        else begin
          exp = sb.pop_front();
          if ({out_data, out_exc} !== exp)
            $display("FAIL skid_sb got %h/%0d exp %h/%0d",
                     out_data, out_exc, exp.d, exp.e);
          else passed++;
        end
      end
      tick();
    end
    total++;
    if (sb.size() != 0) $display("FAIL skid_left got %0d exp 0", sb.size());
    else passed++;
  endtask
`else
  task automatic test_comb_ready();
    beat_t exp;
    do_reset();
    drive(1'b1, 32'h31, '0, 1'b1, 1'b0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) drive(1'b0, '0, '0, 1'b1, 1'b0);
      else drive(1'b1, 32'h32, '0, (c == 2), 1'b0);
      if (c == 1) begin
        total++;
        if (in_ready !== 1'b0) $display("FAIL comb_stall got %b exp 0", in_ready);
        else passed++;
      end
      if (c == 2) begin
        total++;
        if (in_ready !== 1'b1) $display("FAIL comb_go got %b exp 1", in_ready);
        else passed++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL comb_sb got %h exp none", out_data);
        else begin
          exp = sb.pop_front();
          if ({out_data, out_exc} !== exp)
            $display("FAIL comb_sb got %h/%0d exp %h/%0d",
                     out_data, out_exc, exp.d, exp.e);
          else passed++;
        end
      end
      tick();
    end
    total++;
    if (sb.size() != 0) $display("FAIL comb_left got %0d exp 0", sb.size());
    else passed++;
  endtask
`endif

  task automatic test_flush();
    logic [1:0] exp_occ;
    do_reset();
    drive(1'b1, 32'h41, '0, 1'b0, 1'b0);
    tick();
`ifdef PIPE_STAGE_SKID_EN
    drive(1'b1, 32'h42, '0, 1'b0, 1'b0);
    tick();
    exp_occ = 2'd2;
`else
    exp_occ = 2'd1;
`endif
    drive(1'b1, 32'h99, '0, 1'b0, 1'b1);
    total++;
    if (in_ready !== 1'b0 || occupancy !== exp_occ)
      $display("FAIL flush_cycle got rdy=%b occ=%0d exp 0/%0d",
               in_ready, occupancy, exp_occ);
    else passed++;
    tick();
    sb.delete();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_exc !== '0 || occupancy !== 2'd0)
      $display("FAIL flush_bubble got v=%b d=%h e=%0d occ=%0d exp 0/0/0/0",
               out_valid, out_data, out_exc, occupancy);
    else passed++;
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b0) $display("FAIL flush_noconsume got %b exp 0", out_valid);
    else passed++;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 32'h61, '0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      if (i == 10) begin
        total++;
        if (stall_cnt !== 4'd10) $display("FAIL sat_mid got %0d exp 10", stall_cnt);
        else passed++;
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++;
    if (stall_cnt !== 4'd15) $display("FAIL sat_top got %0d exp 15", stall_cnt);
    else passed++;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    sb.delete();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++;
    if (stall_cnt !== 4'd15 || out_valid !== 1'b0)
      $display("FAIL sat_flush got cnt=%0d v=%b exp 15/0", stall_cnt, out_valid);
    else passed++;
    drive(1'b1, 32'h62, '0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    drive(1'b1, 32'h63, '0, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    sb.delete();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++;
    if (stall_cnt !== '0 || occupancy !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL sat_reset got cnt=%0d occ=%0d v=%b exp 0/0/0",
               stall_cnt, occupancy, out_valid);
    else passed++;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_exc    = '0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_fence();
`ifdef PIPE_STAGE_SKID_EN
    test_skid();
`else
    test_comb_ready();
`endif
    test_flush();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
